// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPEC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SPEC  = S_SPEC,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_DRAIN = S_DRAIN,
        ST_WB    = S_WB
    } state_t;

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of the RISC-V divide special cases and their
// architecturally defined results (divide-by-zero, signed overflow).
module div_special_detect
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            signed_i,
    output logic            is_dz_o,
    output logic            is_ovf_o,
    output logic [XLEN-1:0] spec_quot_o,
    output logic [XLEN-1:0] spec_rem_o
);

    assign is_dz_o  = (rs2_i == '0);
    assign is_ovf_o = signed_i && (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);

    // The two cases are mutually exclusive, so is_dz_o alone selects the result.
    assign spec_quot_o = is_dz_o ? ALL_ONES : INT_MIN;
    assign spec_rem_o  = is_dz_o ? rs1_i : '0;

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequencer between EX and the shared iterative divider (DIV/DIVU/REM/REMU).
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DW  = XLEN,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_i,
    input  logic [1:0]     req_op_i,
    input  logic [DW-1:0]  req_rs1_i,
    input  logic [DW-1:0]  req_rs2_i,
    input  logic [RAW-1:0] req_rd_i,
    output logic           req_ready_o,
    input  logic           flush_i,
    output logic           stall_o,
    output logic           wb_valid_o,
    output logic [RAW-1:0] wb_rd_o,
    output logic [DW-1:0]  wb_data_o,
    output logic           div_start_o,
    output logic [DW-1:0]  div_dividend_o,
    output logic [DW-1:0]  div_divisor_o,
    output logic           div_signed_o,
    input  logic           div_done_i,
    input  logic [DW-1:0]  div_quot_i,
    input  logic [DW-1:0]  div_rem_i
);

    state_t         state_q;
    logic [DW-1:0]  rs1_q, rs2_q, res_q;
    logic [RAW-1:0] rd_q;
    logic           sgn_q, rem_q, wb_q, start_q;

    logic           req_signed, req_rem, accept;
    logic           is_dz, is_ovf, cache_hit;
    logic [DW-1:0]  spec_quot, spec_rem, cache_quot, cache_rem;

    assign req_signed = op_is_signed(req_op_i);
    assign req_rem    = op_is_rem(req_op_i);
    assign accept     = (state_q == ST_IDLE) && req_valid_i && !flush_i;

    div_special_detect u_special (
        .rs1_i       (req_rs1_i),
        .rs2_i       (req_rs2_i),
        .signed_i    (req_signed),
        .is_dz_o     (is_dz),
        .is_ovf_o    (is_ovf),
        .spec_quot_o (spec_quot),
        .spec_rem_o  (spec_rem)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic          c_valid_q, c_sgn_q;
    logic [DW-1:0] c_rs1_q, c_rs2_q, c_quot_q, c_rem_q;

    assign cache_hit  = c_valid_q && (c_rs1_q == req_rs1_i) && (c_rs2_q == req_rs2_i)
                        && (c_sgn_q == req_signed);
    assign cache_quot = c_quot_q;
    assign cache_rem  = c_rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid_q <= 1'b0;
            c_sgn_q   <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_quot_q  <= '0;
            c_rem_q   <= '0;
        end else if (state_q == ST_WAIT && div_done_i && !flush_i) begin
            c_valid_q <= 1'b1;
            c_sgn_q   <= sgn_q;
            c_rs1_q   <= rs1_q;
            c_rs2_q   <= rs2_q;
            c_quot_q  <= div_quot_i;
            c_rem_q   <= div_rem_i;
        end else if ((state_q == ST_WAIT || state_q == ST_DRAIN) && flush_i) begin
            c_valid_q <= 1'b0;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_quot = '0;
    assign cache_rem  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= 1'b0;
            wb_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            wb_q    <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rs1_q <= req_rs1_i;
                        rs2_q <= req_rs2_i;
                        rd_q  <= req_rd_i;
                        sgn_q <= req_signed;
                        rem_q <= req_rem;
                        if (is_dz || is_ovf) begin
                            res_q   <= req_rem ? spec_rem : spec_quot;
                            wb_q    <= 1'b1;
                            state_q <= ST_SPEC;
                        end else if (cache_hit) begin
                            res_q   <= req_rem ? cache_rem : cache_quot;
                            wb_q    <= 1'b1;
                            state_q <= ST_WB;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_SPEC: state_q <= ST_IDLE;
                ST_ISSUE: begin
                    // The start pulse is registered, so a flush here never reaches the divider.
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        state_q <= div_done_i ? ST_IDLE : ST_DRAIN;
                    end else if (div_done_i) begin
                        res_q   <= rem_q ? div_rem_i : div_quot_i;
                        wb_q    <= 1'b1;
                        state_q <= ST_WB;
                    end
                end
                ST_DRAIN: if (div_done_i) state_q <= ST_IDLE;
                ST_WB:    state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_valid_o     = wb_q && !flush_i;
    assign wb_rd_o        = rd_q;
    assign wb_data_o      = res_q;
    assign req_ready_o    = accept;
    assign div_start_o    = start_q;
    assign div_dividend_o = rs1_q;
    assign div_divisor_o  = rs2_q;
    assign div_signed_o   = sgn_q;

    // Busy states hold the pipeline, released on the cycle the result is written back.
    always_comb begin
        stall_o = accept;
        case (state_q)
            ST_SPEC, ST_ISSUE, ST_WAIT, ST_DRAIN: stall_o = !wb_valid_o;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized scoreboard bench for div_issue_ctrl with a behavioural divider model.
module tb_div_issue_ctrl;

    localparam logic [1:0] T_DIV = 2'b00, T_DIVU = 2'b01, T_REM = 2'b10, T_REMU = 2'b11;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  req_op_i = '0;
    logic [31:0] req_rs1_i = '0, req_rs2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        req_ready_o, stall_o, wb_valid_o, div_start_o, div_signed_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o, div_dividend_o, div_divisor_o;
    logic        div_done_i = 1'b0;
    logic [31:0] div_quot_i = '0, div_rem_i = '0;

    div_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_rs1_i(req_rs1_i),
        .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i), .req_ready_o(req_ready_o),
        .flush_i(flush_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
        .div_divisor_o(div_divisor_o), .div_signed_o(div_signed_o),
        .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // RISC-V M-extension arithmetic, special cases included.
    task automatic golden(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          wb_cyc;
        int          starts;
    } exp_t;
    exp_t exp_q[$];
    int   lat_q[$];

    // Reference-model state
    int          exp_starts = 0;
    bit          m_valid = 1'b0;
    bit          m_sgn;
    logic [31:0] m_a, m_b;

    // Behavioural divider: done arrives lat cycles after the start pulse.
    int start_cnt = 0;
    initial begin
        bit          busy = 1'b0;
        int          target = 0;
        logic [31:0] dq, dr, da, db;
        forever begin
            @(negedge clk);
            div_done_i = 1'b0;
            if (rst) begin
                busy = 1'b0;
                continue;
            end
            if (busy && cyc == target) begin
                chk("operand_hold", {div_dividend_o, div_divisor_o}, {da, db});
                div_done_i = 1'b1;
                div_quot_i = dq;
                div_rem_i  = dr;
                busy = 1'b0;
            end
            if (div_start_o) begin
                start_cnt++;
                chk("start_while_busy", 64'(busy), 64'd0);
                da = div_dividend_o;
                db = div_divisor_o;
                golden(div_signed_o, da, db, dq, dr);
                busy = 1'b1;
                if (lat_q.size() == 0) begin
                    fail_now("unexpected_start");
                    target = cyc + 5;
                end else begin
                    target = cyc + lat_q.pop_front();
                end
            end
        end
    end

    // Monitor: every writeback pops one expected transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_wb");
                end else begin
                    e = exp_q.pop_front();
                    $display("wb  rd=%0d data=%08h cycle=%0d (expected rd=%0d data=%08h cycle=%0d)",
                             wb_rd_o, wb_data_o, cyc, e.rd, e.data, e.wb_cyc);
                    chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                    chk("wb_data", 64'(wb_data_o), 64'(e.data));
                    chk("wb_cycle", 64'(cyc), 64'(e.wb_cyc));
                    chk("start_count", 64'(start_cnt), 64'(e.starts));
                end
            end
        end
    end

    // mode 0: normal; 1: flushed right after accept (SPEC/ISSUE/WB); 2: flushed after divider start
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int mode, output int acc);
        logic        sgn, spec, hit;
        logic [31:0] q, r;
        int          n;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
        acc = -1;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        if (acc < 0) begin
            fail_now("accept_timeout");
            return;
        end
        sgn  = !op[0];
        spec = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit  = CACHE_EN && m_valid && m_a == a && m_b == b && m_sgn == sgn;
        golden(sgn, a, b, q, r);
        if (!spec && !hit && mode != 1) begin
            exp_starts++;
            lat_q.push_back(lat);
            m_valid = (mode == 0);
            m_a = a; m_b = b; m_sgn = sgn;
        end
        if (mode == 0)
            exp_q.push_back('{rd, op[1] ? r : q, (spec || hit) ? acc + 1 : acc + 3 + lat, exp_starts});
    endtask

    initial begin
        int          acc, acc2;
        logic [31:0] a, b, pa, pb;
        logic [1:0]  op;

        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_start", 64'(div_start_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_wb_data_rd", {27'd0, wb_rd_o, wb_data_o}, 64'd0);
        chk("rst_operands", {div_dividend_o, div_divisor_o}, 64'd0);
        chk("rst_signed", 64'(div_signed_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(T_DIV,  32'd100, 32'd7, 5'd1, 33, 0, acc);
        send(T_REMU, 32'd5, 32'd0, 5'd2, 7, 0, acc);
        send(T_DIVU, 32'd5, 32'd0, 5'd3, 7, 0, acc);
        send(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 7, 0, acc);
        send(T_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 7, 0, acc);
        send(T_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 5, 0, acc);
        send(T_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, 6, 0, acc);
        send(T_DIV,  32'd100, 32'd7, 5'd8, 10, 0, acc);
        send(T_REM,  32'd100, 32'd7, 5'd9, 10, 0, acc);

        // Flush five cycles into WAIT; the next request must wait for the drain.
        send(T_DIV, 32'd1000, 32'd3, 5'd10, 33, 2, acc);
        while (cyc != acc + 7) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall_in_wait", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("stall_in_drain", 64'(stall_o), 64'd1);
        send(T_REMU, 32'd1000, 32'd7, 5'd11, 4, 0, acc2);
        chk("drain_accept_cycle", 64'(acc2), 64'(acc + 36));

        // Flush right after accept: special case in SPEC, normal op in ISSUE.
        send(T_DIVU, 32'd9, 32'd0, 5'd12, 3, 1, acc);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        send(T_DIVU, 32'd12345, 32'd17, 5'd13, 3, 1, acc);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        send(T_DIVU, 32'd77, 32'd8, 5'd14, 3, 0, acc);

        pa = 32'd1; pb = 32'd1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                a = pa; b = pb;
            end else begin
                case ($urandom_range(0, 7))
                    0:       a = 32'h8000_0000;
                    1:       a = 32'($urandom_range(0, 20));
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1:       b = 32'hFFFF_FFFF;
                    2:       b = 32'($urandom_range(1, 9));
                    default: b = $urandom;
                endcase
            end
            send(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(1, 40), 0, acc);
            pa = a; pb = b;
        end

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        chk("outstanding_at_end", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
